// File: rtl/bip1_debug_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// bip1_debug_unit
//
// UART-side debug controller for the BIP1 system. It waits for a start
// command byte from the host, then enables the CPU and counts its clock
// cycles. When the CPU halts, the block freezes the CPU and snapshots PC,
// ACC and the cycle count. It then streams an 8-byte frame back through the
// UART transmitter:
//   PC[15:8] PC[7:0] ACC[15:8] ACC[7:0] CNT[31:24] CNT[23:16] CNT[15:8] CNT[7:0]
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        asynchronous active-low reset
//   i_rx_data    byte from the UART receiver
//   i_rx_valid   one-cycle pulse, i_rx_data valid
//   i_tx_done    one-cycle pulse, transmitter finished the current byte
//   o_tx_data    byte to transmit (held while the byte is in flight)
//   o_tx_start   one-cycle pulse, start transmitting o_tx_data
//   i_pc         CPU program counter
//   i_acc        CPU accumulator
//   i_cpu_halt   CPU has executed HLT (level)
//   o_cpu_enable CPU clock enable
//   o_busy       high in every state except IDLE
// ---------------------------------------------------------------------------
module bip1_debug_unit #(
    parameter int              NB_ADDR   = 11,
    parameter int              NB_DATA   = 16,
    parameter int              NB_CNT    = 32,
    parameter int              DBIT      = 8,
    parameter logic [DBIT-1:0] CMD_START = 8'h01
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [DBIT-1:0]    i_rx_data,
    input  logic               i_rx_valid,
    input  logic               i_tx_done,
    output logic [DBIT-1:0]    o_tx_data,
    output logic               o_tx_start,
    input  logic [NB_ADDR-1:0] i_pc,
    input  logic [NB_DATA-1:0] i_acc,
    input  logic               i_cpu_halt,
    output logic               o_cpu_enable,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        SEND    = 2'd2,
        WAIT_TX = 2'd3
    } state_t;

    localparam logic [2:0] LAST_BYTE = 3'd7;

    state_t              state;
    logic [NB_CNT-1:0]   cnt;
    logic [15:0]         pc_snap;
    logic [NB_DATA-1:0]  acc_snap;
    logic [2:0]          idx;
    logic [7:0]          frame_byte;

    // Byte selector for the outgoing frame, MSB first within each field.
    // The counter needs no separate snapshot: it only moves while in RUN,
    // so it is frozen for the whole frame.
    always_comb begin
        // NOTE: default assignment first so every path drives frame_byte and
        // no latch is inferred.
        frame_byte = 8'h00;
        case (idx)
            3'd0:    frame_byte = pc_snap[15:8];
            3'd1:    frame_byte = pc_snap[7:0];
            3'd2:    frame_byte = acc_snap[15:8];
            3'd3:    frame_byte = acc_snap[7:0];
            3'd4:    frame_byte = cnt[31:24];
            3'd5:    frame_byte = cnt[23:16];
            3'd6:    frame_byte = cnt[15:8];
            3'd7:    frame_byte = cnt[7:0];
            default: frame_byte = 8'h00;
        endcase
    end

    // Single registered FSM; every output is a flop so the CPU enable and
    // the UART strobe are glitch-free.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            pc_snap      <= '0;
            acc_snap     <= '0;
            idx          <= '0;
            o_tx_data    <= '0;
            o_tx_start   <= 1'b0;
            o_cpu_enable <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // updates from pre-edge values regardless of statement order.
            // The start strobe defaults low, giving a single-cycle pulse.
            o_tx_start <= 1'b0;

            case (state)
                IDLE: begin
                    // Halt is ignored here; only the start command matters.
                    if (i_rx_valid && (i_rx_data == CMD_START)) begin
                        cnt          <= '0;
                        o_cpu_enable <= 1'b1;
                        o_busy       <= 1'b1;
                        state        <= RUN;
                    end
                end

                RUN: begin
                    // The halt-sampling edge is counted too; saturate
                    // rather than wrap on very long runs.
                    if (cnt != '1) begin
                        cnt <= cnt + NB_CNT'(1);
                    end
                    if (i_cpu_halt) begin
                        pc_snap      <= 16'(i_pc);
                        acc_snap     <= i_acc;
                        o_cpu_enable <= 1'b0;
                        idx          <= '0;
                        state        <= SEND;
                    end
                end

                SEND: begin
                    o_tx_data  <= DBIT'(frame_byte);
                    o_tx_start <= 1'b1;
                    state      <= WAIT_TX;
                end

                WAIT_TX: begin
                    // o_tx_data holds until the transmitter reports done.
                    if (i_tx_done) begin
                        if (idx == LAST_BYTE) begin
                            o_busy <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= SEND;
                        end
                    end
                end

                default: begin
                    o_cpu_enable <= 1'b0;
                    o_busy       <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bip1_debug_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_bip1_debug_unit
//
// Scoreboard bench for bip1_debug_unit. Stimulus pushes the expected frame
// bytes into a queue; a monitor pops and compares on every o_tx_start pulse.
// A responder answers each transmitted byte with i_tx_done three cycles later.
// ---------------------------------------------------------------------------
module tb_bip1_debug_unit;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        resp_done = 1'b0;
    logic        noise_done = 1'b0;
    logic        tx_done;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic [10:0] pc = '0;
    logic [15:0] acc = '0;
    logic        halt = 1'b0;
    logic        cpu_enable;
    logic        busy;

    int          n_checks = 0;
    int          n_fail = 0;
    int          done_count = 0;
    logic [7:0]  exp_q[$];
    logic        prev_start = 1'b0;

    assign tx_done = resp_done | noise_done;

    always #5 i_clk = ~i_clk;

    bip1_debug_unit dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .i_tx_done    (tx_done),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .i_pc         (pc),
        .i_acc        (acc),
        .i_cpu_halt   (halt),
        .o_cpu_enable (cpu_enable),
        .o_busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every transmitted byte against the scoreboard.
    initial begin
        forever begin
            @(negedge i_clk);
            if (tx_start) begin
                check("tx_start_width", {31'd0, prev_start}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_tx: got byte 0x%0h, expected no transmission", tx_data);
                end else begin
                    check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
                end
            end
            prev_start = tx_start;
        end
    end

    // Responder: emulates the UART transmitter finishing each byte.
    initial begin
        forever begin
            @(negedge i_clk);
            if (tx_start) begin
                repeat (3) @(posedge i_clk);
                #1 resp_done = 1'b1;
                @(posedge i_clk);
                #1 resp_done = 1'b0;
                done_count++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge i_clk);
        #1 rx_data = b;
        rx_valid = 1'b1;
        @(posedge i_clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic push_frame(input logic [15:0] p, input logic [15:0] a, input logic [31:0] c);
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[7:0]);
        exp_q.push_back(a[15:8]);
        exp_q.push_back(a[7:0]);
        exp_q.push_back(c[31:24]);
        exp_q.push_back(c[23:16]);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[7:0]);
    endtask

    task automatic wait_done(input int target, input string name);
        int cyc = 0;
        while (done_count < target && cyc < 400) begin
            @(negedge i_clk);
            cyc++;
        end
        check(name, done_count, target);
    endtask

    // Start a run, keep halt low for 'low' RUN edges, halt on the next one.
    task automatic run_frame(input logic [10:0] p, input logic [15:0] a, input int low,
                             input string name);
        int base = done_count;
        push_frame({5'd0, p}, a, low + 1);
        send_byte(8'h01);
        check({name, "_enable_on"}, {31'd0, cpu_enable}, 32'd1);
        check({name, "_busy_on"}, {31'd0, busy}, 32'd1);
        repeat (low) @(posedge i_clk);
        #1 halt = 1'b1;
        pc = p;
        acc = a;
        @(posedge i_clk);
        #1 halt = 1'b0;
        check({name, "_enable_off"}, {31'd0, cpu_enable}, 32'd0);
        wait_done(base + 8, {name, "_frame_done"});
        @(negedge i_clk);
        check({name, "_busy_end"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        check({name, "_tx_start"}, {31'd0, tx_start}, 32'd0);
        check({name, "_enable"}, {31'd0, cpu_enable}, 32'd0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int base;

        // Reset held with random inputs.
        for (int i = 0; i < 8; i++) begin
            @(posedge i_clk);
            #1 rx_data = 8'($urandom);
            rx_valid = 1'($urandom);
            noise_done = 1'($urandom);
            pc = 11'($urandom);
            acc = 16'($urandom);
            halt = 1'($urandom);
            #1 check_outputs_zero("reset_hold");
        end
        rx_valid = 1'b0;
        noise_done = 1'b0;
        halt = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        repeat (5) @(negedge i_clk);
        check_outputs_zero("after_release");

        // Non-start bytes are discarded.
        send_byte(8'h55);
        check("byte55_enable", {31'd0, cpu_enable}, 32'd0);
        check("byte55_busy", {31'd0, busy}, 32'd0);
        send_byte(8'h00);
        check("byte00_enable", {31'd0, cpu_enable}, 32'd0);
        repeat (4) @(negedge i_clk);
        check("byte00_busy", {31'd0, busy}, 32'd0);

        // Normal run: 9 low edges plus the halt edge, frame 01 23 BE EF 00 00 00 0A.
        run_frame(11'h123, 16'hBEEF, 9, "normal");

        // Immediate halt: count field must be 1.
        base = done_count;
        halt = 1'b1;
        pc = 11'h7FF;
        acc = 16'h1234;
        push_frame(16'h07FF, 16'h1234, 32'd1);
        send_byte(8'h01);
        check("imm_enable_on", {31'd0, cpu_enable}, 32'd1);
        @(posedge i_clk);
        #1 check("imm_enable_off", {31'd0, cpu_enable}, 32'd0);
        wait_done(base + 8, "imm_frame_done");
        halt = 1'b0;
        @(negedge i_clk);
        check("imm_busy_end", {31'd0, busy}, 32'd0);

        // Ignored traffic: start bytes during RUN and WAIT_TX; count must be 4.
        base = done_count;
        push_frame(16'h0456, 16'hA5A5, 32'd4);
        send_byte(8'h01);
        send_byte(8'h01);
        check("ign_run_enable", {31'd0, cpu_enable}, 32'd1);
        @(posedge i_clk);
        #1 halt = 1'b1;
        pc = 11'h456;
        acc = 16'hA5A5;
        @(posedge i_clk);
        #1 halt = 1'b0;
        for (int i = 0; i < 20 && !tx_start; i++) @(negedge i_clk);
        send_byte(8'h01);
        wait_done(base + 8, "ign_frame_done");
        @(negedge i_clk);
        check("ign_busy_end", {31'd0, busy}, 32'd0);
        check("ign_enable_end", {31'd0, cpu_enable}, 32'd0);
        repeat (3) @(negedge i_clk);
        // Fresh run after the ignored traffic starts from a cleared count.
        run_frame(11'h000, 16'h0000, 2, "fresh");

        // Reset mid-frame after byte 3's tx_done.
        base = done_count;
        push_frame(16'h03C3, 16'h0F0F, 32'd6);
        send_byte(8'h01);
        repeat (5) @(posedge i_clk);
        #1 halt = 1'b1;
        pc = 11'h3C3;
        acc = 16'h0F0F;
        @(posedge i_clk);
        #1 halt = 1'b0;
        for (int i = 0; i < 200 && done_count < base + 4; i++) @(negedge i_clk);
        check("abort_reached_byte3", done_count, base + 4);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        i_rst = 1'b0;
        #1 check_outputs_zero("abort_async");
        exp_q.delete();
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        check_outputs_zero("abort_idle");
        run_frame(11'h001, 16'h8000, 1, "after_abort");

        repeat (5) @(negedge i_clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bip1_debug_unit.md
# bip1_debug_unit

UART-side debug controller for the BIP1 system, placed between the UART byte interface and the CPU. It waits for a start command byte from the host, enables the CPU and counts its clock cycles. When the CPU signals halt, it freezes the CPU and snapshots PC, ACC and the cycle count. It then streams the snapshot back to the host as an 8-byte frame through the UART transmitter.

## Interface
Parameters:
- NB_ADDR, 11, program counter width (must be ≤ 16)
- NB_DATA, 16, accumulator width (fixed at 16)
- NB_CNT, 32, cycle counter width (fixed at 32)
- DBIT, 8, UART data byte width
- CMD_START, 8'h01, command byte that launches the CPU

Ports:
- i_clk  in  1  system clock; all logic on the rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_rx_data  in  DBIT  byte from UART receiver
- i_rx_valid  in  1  one-cycle pulse; i_rx_data is valid
- i_tx_done  in  1  one-cycle pulse; UART transmitter finished the current byte
- o_tx_data  out  DBIT  byte to transmit
- o_tx_start  out  1  one-cycle pulse; start transmitting o_tx_data
- i_pc  in  NB_ADDR  CPU program counter
- i_acc  in  NB_DATA  CPU accumulator
- i_cpu_halt  in  1  CPU has executed HLT (level)
- o_cpu_enable  out  1  CPU clock-enable
- o_busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, RUN, SEND, WAIT_TX.
- IDLE: o_cpu_enable=0, o_busy=0.
  - i_rx_valid with i_rx_data==CMD_START: clear the counter, go to RUN.
  - Any other byte is discarded and the state stays IDLE.
  - i_cpu_halt is ignored.
- RUN: o_cpu_enable=1. The counter increments on every edge while in RUN.
  - Increment saturates at all-ones; it does not wrap.
  - On the edge that samples i_cpu_halt=1, the block:
    - counts that cycle as well;
    - latches i_pc, zero-extended to 16 bits, and i_acc;
    - drops o_cpu_enable;
    - sets the byte index to 0 and goes to SEND.
- SEND: drive o_tx_data = frame[index] and pulse o_tx_start for exactly one cycle, then go to WAIT_TX.
- WAIT_TX: hold o_tx_data.
  - On i_tx_done with index<7: index+1, go to SEND.
  - On i_tx_done with index==7: go to IDLE.
- Frame order, MSB first within each field:
  - byte 0: PC[15:8]
  - byte 1: PC[7:0]
  - byte 2: ACC[15:8]
  - byte 3: ACC[7:0]
  - bytes 4–7: CNT[31:24], CNT[23:16], CNT[15:8], CNT[7:0]
- i_rx_valid is ignored in RUN, SEND and WAIT_TX; no command queuing.
- i_tx_done outside WAIT_TX is ignored.
- Snapshot registers hold their values from latch until the next halt latch.

## Timing
- Reset values (i_rst=0, asynchronous): state IDLE, o_cpu_enable=0, o_tx_start=0, o_tx_data=0, o_busy=0, counter=0, index=0, snapshots=0.
- Reset mid-run or mid-frame aborts immediately. No partial bytes are resumed after release.
- All outputs are registered.
- Start latency: the start byte is sampled at edge E. o_cpu_enable=1 and o_busy=1 are visible after E.
- Count: N edges in RUN, including the halt-sampling edge, give CNT=N.
- Halt latency: halt is sampled at edge H.
  - o_cpu_enable=0 after H.
  - The first o_tx_start pulse is high during the cycle after H+1, one cycle in SEND.
- Byte pacing: i_tx_done at edge D gives the next o_tx_start one cycle later, i.e. high after D+1.
- Frame completes, with o_busy=0, after the edge sampling the 8th i_tx_done.
- If i_cpu_halt is already high on the first RUN edge, CNT=1 and the frame is sent immediately.

## Test plan
- Reset: hold i_rst=0 with random inputs. All outputs are 0. Release; the block stays IDLE with no tx pulse.
- Non-start bytes: send 0x55 and 0x00 in IDLE. o_cpu_enable stays 0 and no frame is produced.
- Normal run: send 0x01, keep halt low for 9 RUN edges, assert halt with i_pc=11'h123 and i_acc=16'hBEEF. Frame must be 01 23 BE EF 00 00 00 0A. tx_done is answered with a 3-cycle delay per byte.
- Immediate halt: i_cpu_halt high before start. Frame count field is 00 00 00 01.
- Ignored traffic: inject i_rx_valid=0x01 during RUN and WAIT_TX. No restart occurs; after the frame, the block is IDLE and o_busy=0. A further 0x01 starts a fresh run with the count cleared.
- Reset mid-frame: assert i_rst after byte 3's tx_done. Outputs go to 0 asynchronously. A new run after release sends a complete 8-byte frame from byte 0.
